counter_mode_sched: RTL and testbench

- Sequencer that drives the 2-bit mode input (`in`, legal values 1..3) of the display counter from a programmed schedule.
- Each schedule entry is a (mode, duration) pair. Each mode is held for its duration in clock cycles.
- Entries are played in order, once or looping.
- Sits between the configuration bus and the counter, replacing hand-timed mode switching.

---
 rtl/counter_mode_sched_pkg.sv | 19 +
 rtl/counter_mode_sched_mem.sv | 46 ++++
 rtl/counter_mode_sched.sv | 164 ++++++++++++++++
 tb/tb_counter_mode_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_mode_sched_pkg.sv
// rtl/counter_mode_sched_pkg.sv - shared mode constants and FSM state type for the mode scheduler
//
// Purpose : constants and types used by counter_mode_sched and sched_mem.
// Contents: MODE_A/B/C are the legal counter modes; MODE_IDLE is what the
//           counter sees whenever no schedule is playing.
//           state_t is the two-state playback FSM encoding.
package counter_sched_pkg;

   localparam logic [1:0] MODE_A    = 2'd1;
   localparam logic [1:0] MODE_B    = 2'd2;
   localparam logic [1:0] MODE_C    = 2'd3;
   localparam logic [1:0] MODE_IDLE = MODE_A;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

endpackage

// File: rtl/counter_mode_sched_mem.sv
// rtl/counter_mode_sched_mem.sv - schedule register file, one (mode, duration) pair per entry
//
// Purpose : DEPTH x (2+DUR_W) register file, synchronous write, asynchronous read.
// Ports   : clk, rst    - clock, synchronous active-low reset (entries -> mode 1, dur 1)
//           we          - write enable (already qualified by the caller)
//           waddr       - entry to write
//           wmode, wdur - data written
//           raddr       - entry to read
//           rmode, rdur - combinational read data
module sched_mem
   import counter_sched_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DUR_W = 8,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [1:0]       wmode,
   input  logic [DUR_W-1:0] wdur,
   input  logic [IDX_W-1:0] raddr,
   output logic [1:0]       rmode,
   output logic [DUR_W-1:0] rdur
);

   logic [1:0]       mode_q [DEPTH];
   logic [DUR_W-1:0] dur_q  [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mode_q[i] <= MODE_A;
            dur_q[i]  <= DUR_W'(1);
         end
      end else if (we) begin
         mode_q[waddr] <= wmode;
         dur_q[waddr]  <= wdur;
      end
   end

   assign rmode = mode_q[raddr];
   assign rdur  = dur_q[raddr];

endmodule

// File: rtl/counter_mode_sched.sv
// rtl/counter_mode_sched.sv - plays a programmed (mode, duration) schedule onto the display counter mode input
//
// Purpose : sequences the counter's 2-bit mode input from a schedule of
//           (mode, duration) entries, once or looping.
// Ports   : clk, rst           - clock, synchronous active-low reset
//           cfg_we/addr/mode/dur - schedule entry write (IDLE only, mode != 0)
//           cfg_err            - one-cycle pulse after a rejected write
//           num_entries        - entries to play, clamped to DEPTH, sampled at start
//           loop_en            - wrap to entry 0 after the last one, sampled at start
//           start, stop        - begin playback from IDLE / abort playback
//           mode_out           - registered mode to the counter, never 0
//           busy               - high while playing
//           done               - one-cycle pulse at the end of a non-looping run
//                                (also when started with zero entries)
//           cur_idx            - entry currently driving mode_out
module counter_mode_sched
   import counter_sched_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DUR_W = 8,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_addr,
   input  logic [1:0]       cfg_mode,
   input  logic [DUR_W-1:0] cfg_dur,
   output logic             cfg_err,
   input  logic [IDX_W:0]   num_entries,
   input  logic             loop_en,
   input  logic             start,
   input  logic             stop,
   output logic [1:0]       mode_out,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] cur_idx
);

   localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

   state_t           state, state_nxt;
   logic [DUR_W-1:0] hold;
   logic [IDX_W:0]   n_lat;
   logic             loop_lat;

   logic             wr_ok;
   logic [IDX_W:0]   n_eff;
   logic             last_entry;
   logic             launch;
   logic             load;
   logic [IDX_W-1:0] load_idx;
   logic             enter_idle;
   logic             done_nxt;
   logic [1:0]       rd_mode;
   logic [DUR_W-1:0] rd_dur;

   // The schedule is frozen while playing, so mode/duration can be read
   // combinationally at the moment an entry is loaded.
   assign wr_ok = (state == S_IDLE) && (cfg_mode != 2'd0) &&
                  ({1'b0, cfg_addr} < DEPTH_L);

   assign n_eff      = (num_entries > DEPTH_L) ? DEPTH_L : num_entries;
   assign last_entry = ({1'b0, cur_idx} == (n_lat - 1'b1));
   assign busy       = (state == S_RUN);

   sched_mem #(
      .DEPTH (DEPTH),
      .DUR_W (DUR_W),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (cfg_we && wr_ok),
      .waddr (cfg_addr),
      .wmode (cfg_mode),
      .wdur  (cfg_dur),
      .raddr (load_idx),
      .rmode (rd_mode),
      .rdur  (rd_dur)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      launch     = 1'b0;
      load       = 1'b0;
      load_idx   = '0;
      enter_idle = 1'b0;
      done_nxt   = 1'b0;
      case (state)
         S_IDLE: begin
            // stop on the same edge as start cancels the start
            if (start && !stop) begin
               if (n_eff != '0) begin
                  state_nxt = S_RUN;
                  launch    = 1'b1;
                  load      = 1'b1;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (stop) begin
               state_nxt  = S_IDLE;
               enter_idle = 1'b1;
            end else if (hold == '0) begin
               if (!last_entry) begin
                  load     = 1'b1;
                  load_idx = cur_idx + 1'b1;
               end else if (loop_lat) begin
                  load = 1'b1;
               end else begin
                  state_nxt  = S_IDLE;
                  enter_idle = 1'b1;
                  done_nxt   = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mode_out <= MODE_IDLE;
         cur_idx  <= '0;
         hold     <= '0;
         n_lat    <= '0;
         loop_lat <= 1'b0;
         done     <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         done    <= done_nxt;
         cfg_err <= cfg_we && !wr_ok;
         if (launch) begin
            n_lat    <= n_eff;
            loop_lat <= loop_en;
         end
         if (load) begin
            cur_idx  <= load_idx;
            mode_out <= rd_mode;
            // hold counts the remaining extra cycles; dur 0 plays like dur 1
            hold     <= (rd_dur == '0) ? '0 : rd_dur - 1'b1;
         end else if (enter_idle) begin
            cur_idx  <= '0;
            mode_out <= MODE_IDLE;
         end else if (state == S_RUN) begin
            hold <= hold - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_counter_mode_sched.sv
// tb/tb_counter_mode_sched.sv - randomized and directed self-checking bench for counter_mode_sched
module tb_counter_mode_sched;

   localparam int DEPTH = 8;
   localparam int DUR_W = 8;
   localparam int IDX_W = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cfg_we = 1'b0;
   logic [IDX_W-1:0] cfg_addr = '0;
   logic [1:0]       cfg_mode = 2'd1;
   logic [DUR_W-1:0] cfg_dur = '0;
   logic             cfg_err;
   logic [IDX_W:0]   num_entries = '0;
   logic             loop_en = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [1:0]       mode_out;
   logic             busy;
   logic             done;
   logic [IDX_W-1:0] cur_idx;

   int n_cmp = 0;
   int n_err = 0;

   // reference schedule, kept as plain integers
   int m_mode [DEPTH];
   int m_dur  [DEPTH];
   int exp_mode [$];
   int exp_idx  [$];

   counter_mode_sched #(
      .DEPTH (DEPTH),
      .DUR_W (DUR_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_mode    (cfg_mode),
      .cfg_dur     (cfg_dur),
      .cfg_err     (cfg_err),
      .num_entries (num_entries),
      .loop_en     (loop_en),
      .start       (start),
      .stop        (stop),
      .mode_out    (mode_out),
      .busy        (busy),
      .done        (done),
      .cur_idx     (cur_idx)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mode[i] = 1;
         m_dur[i]  = 1;
      end
   endtask

   task automatic chk_idle(input string tag, input int exp_done);
      chk({tag, "_mode"}, 32'(mode_out), 1);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), exp_done);
      chk({tag, "_idx"},  32'(cur_idx), 0);
   endtask

   // write one entry while idle; mode 0 must be rejected
   task automatic wr(input int a, input int m, input int d);
      bit ok;
      ok       = (m != 0);
      cfg_we   = 1'b1;
      cfg_addr = IDX_W'(a);
      cfg_mode = 2'(m);
      cfg_dur  = DUR_W'(d);
      tick();
      cfg_we = 1'b0;
      if (ok) begin
         m_mode[a] = m;
         m_dur[a]  = d;
      end
      chk("wr_cfg_err", 32'(cfg_err), 32'(!ok));
   endtask

   // start a run and check every cycle against the expected mode timeline;
   // wr_at >= 0 issues an (illegal) write during the run at that cycle
   task automatic play(input int n, input bit lp, input int cycles, input int wr_at);
      int nn;
      int len;
      exp_mode.delete();
      exp_idx.delete();
      nn = (n > DEPTH) ? DEPTH : n;
      do begin
         for (int i = 0; i < nn; i++) begin
            int d;
            d = (m_dur[i] == 0) ? 1 : m_dur[i];
            for (int j = 0; j < d; j++) begin
               exp_mode.push_back(m_mode[i]);
               exp_idx.push_back(i);
            end
         end
      end while (lp && exp_mode.size() < cycles);
      len = lp ? cycles : exp_mode.size();

      num_entries = (IDX_W+1)'(n);
      loop_en     = lp;
      start       = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < len; k++) begin
         chk("run_mode",  32'(mode_out), exp_mode[k]);
         chk("run_idx",   32'(cur_idx),  exp_idx[k]);
         chk("run_busy",  32'(busy),     1);
         chk("run_done",  32'(done),     0);
         chk("run_cfg_err", 32'(cfg_err), 32'(wr_at >= 0 && k == wr_at + 1));
         if (k == wr_at) begin
            cfg_we   = 1'b1;
            cfg_addr = '0;
            cfg_mode = 2'd3;
            cfg_dur  = 8'd9;
         end
         tick();
         cfg_we = 1'b0;
      end
      if (lp) begin
         stop = 1'b1;
         tick();
         stop = 1'b0;
         chk_idle("stop", 0);
         tick();
         chk("stop_done_later", 32'(done), 0);
      end else begin
         chk_idle("end", 1);
         tick();
         chk("end_done_pulse", 32'(done), 0);
      end
   endtask

   initial begin
      model_reset();

      // reset state
      tick();
      tick();
      chk_idle("reset", 0);
      chk("reset_cfg_err", 32'(cfg_err), 0);
      rst = 1'b1;
      tick();

      // bring-up schedule (entry 7 keeps its reset value)
      wr(0, 1, 32); wr(1, 2, 17); wr(2, 3, 12); wr(3, 1, 7);
      wr(4, 3, 6);  wr(5, 2, 6);  wr(6, 3, 12);
      play(7, 0, 0, -1);

      // loop wrap with an illegal write mid-run, then stop
      wr(0, 2, 3); wr(1, 3, 2);
      play(2, 1, 20, 5);

      // rejected write in idle, then replay shows memory unchanged
      wr(0, 0, 5);
      tick();
      chk("cfg_err_single_pulse", 32'(cfg_err), 0);
      play(2, 0, 0, -1);

      // degenerate: dur 0 plays one cycle, count clamps to DEPTH
      wr(2, 3, 0); wr(3, 2, 0);
      play(DEPTH + 3, 0, 0, -1);

      // zero entries: done next cycle, never busy
      num_entries = '0;
      start       = 1'b1;
      tick();
      start = 1'b0;
      chk_idle("zero_n", 1);
      tick();
      chk("zero_n_done_clear", 32'(done), 0);

      // start and stop together in idle: no action
      num_entries = 4'd3;
      start       = 1'b1;
      stop        = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk_idle("start_stop", 0);

      // randomized schedules
      for (int it = 0; it < 6; it++) begin
         for (int a = 0; a < DEPTH; a++) begin
            wr(a, $urandom_range(1, 3), $urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0) begin
               wr($urandom_range(0, DEPTH - 1), 0, $urandom_range(0, 255));
            end
         end
         if (it % 3 == 2) begin
            play($urandom_range(1, 2 * DEPTH - 1), 1, $urandom_range(10, 60), -1);
         end else begin
            play($urandom_range(1, 2 * DEPTH - 1), 0, 0, -1);
         end
      end

      // reset during a run re-initialises everything
      num_entries = 4'd5;
      start       = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      model_reset();
      chk_idle("mid_reset", 0);
      chk("mid_reset_cfg_err", 32'(cfg_err), 0);
      play(DEPTH, 0, 0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
